id_stage: RTL and testbench

Instruction-decode stage of the Minisys-2.0 pipelined core. It sits directly downstream of instruction fetch. It latches the fetched instruction and PC+4 into an IF/ID register, reads the 32×32 register file with write-back bypass, and extends the immediate. Decoded operands go to the ID/EX register. It also detects load-use hazards and stalls fetch for one cycle on each one.

---
 rtl/id_stage.sv | 172 +++++++++++++++++
 tb/tb_id_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, 32x32 register file with write-back bypass,
// immediate extension, load-use hazard detection and the ID/EX register.
module id_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Instruction,
    input  logic [31:0] PC_plus_4,
    input  logic        if_valid,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [5:0]  ex_opcode,
    output logic [5:0]  ex_funct,
    output logic [31:0] ex_pc_plus_4
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RIDX = 5;
    localparam int unsigned OPW  = 6;

    localparam logic [OPW-1:0] OP_LW   = 6'b100011;
    localparam logic [OPW-1:0] OP_ANDI = 6'b001100;
    localparam logic [OPW-1:0] OP_ORI  = 6'b001101;
    localparam logic [OPW-1:0] OP_XORI = 6'b001110;

    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc4_q, id_pc4_d;
    logic            id_valid_q, id_valid_d;

    logic [XLEN-1:0] rf_q [NREG];

    logic [RIDX-1:0] id_rs, id_rt, id_rd;
    logic [OPW-1:0]  id_op, id_funct;
    logic [XLEN-1:0] id_rs_data, id_rt_data, id_imm;

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [XLEN-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic [RIDX-1:0] ex_rs_q, ex_rs_d;
    logic [RIDX-1:0] ex_rt_q, ex_rt_d;
    logic [RIDX-1:0] ex_rd_q, ex_rd_d;
    logic [OPW-1:0]  ex_opcode_q, ex_opcode_d;
    logic [OPW-1:0]  ex_funct_q, ex_funct_d;
    logic [XLEN-1:0] ex_pc4_q, ex_pc4_d;

    assign id_op    = id_instr_q[31:26];
    assign id_rs    = id_instr_q[25:21];
    assign id_rt    = id_instr_q[20:16];
    assign id_rd    = id_instr_q[15:11];
    assign id_funct = id_instr_q[5:0];

    // Read ports: r0 is hard zero, a same-cycle write-back wins over the array.
    always_comb begin
        id_rs_data = rf_q[id_rs];
        id_rt_data = rf_q[id_rt];
        if (wb_en && (wb_addr == id_rs)) id_rs_data = wb_data;
        if (wb_en && (wb_addr == id_rt)) id_rt_data = wb_data;
        if (id_rs == '0) id_rs_data = '0;
        if (id_rt == '0) id_rt_data = '0;
    end

    always_comb begin
        case (id_op)
            OP_ANDI, OP_ORI, OP_XORI: id_imm = {16'h0000, id_instr_q[15:0]};
            default:                  id_imm = {{16{id_instr_q[15]}}, id_instr_q[15:0]};
        endcase
    end

    // A load in EX whose destination is read by the decoding instruction.
    assign stall = !reset && ex_valid_q && (ex_opcode_q == OP_LW) && (ex_rt_q != '0)
                   && id_valid_q && ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));

    always_comb begin
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        if (flush) begin
            id_instr_d = '0;
            id_pc4_d   = '0;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            id_instr_d = Instruction;
            id_pc4_d   = PC_plus_4;
            id_valid_d = if_valid;
        end
    end

    always_comb begin
        ex_valid_d   = 1'b0;
        ex_rs_data_d = '0;
        ex_rt_data_d = '0;
        ex_imm_d     = '0;
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        ex_rd_d      = '0;
        ex_opcode_d  = '0;
        ex_funct_d   = '0;
        ex_pc4_d     = '0;
        if (!flush && !stall) begin
            ex_valid_d   = id_valid_q;
            ex_rs_data_d = id_rs_data;
            ex_rt_data_d = id_rt_data;
            ex_imm_d     = id_imm;
            ex_rs_d      = id_rs;
            ex_rt_d      = id_rt;
            ex_rd_d      = id_rd;
            ex_opcode_d  = id_op;
            ex_funct_d   = id_funct;
            ex_pc4_d     = id_pc4_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            id_instr_q   <= '0;
            id_pc4_q     <= '0;
            id_valid_q   <= 1'b0;
            ex_valid_q   <= 1'b0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_opcode_q  <= '0;
            ex_funct_q   <= '0;
            ex_pc4_q     <= '0;
        end else begin
            id_instr_q   <= id_instr_d;
            id_pc4_q     <= id_pc4_d;
            id_valid_q   <= id_valid_d;
            ex_valid_q   <= ex_valid_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_funct_q   <= ex_funct_d;
            ex_pc4_q     <= ex_pc4_d;
        end
    end

    // Register file keeps its contents across reset; writes to r0 are dropped.
    always_ff @(posedge clock) begin
        if (wb_en && (wb_addr != '0)) rf_q[wb_addr] <= wb_data;
    end

    assign ex_valid     = ex_valid_q;
    assign ex_rs_data   = ex_rs_data_q;
    assign ex_rt_data   = ex_rt_data_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_rd        = ex_rd_q;
    assign ex_opcode    = ex_opcode_q;
    assign ex_funct     = ex_funct_q;
    assign ex_pc_plus_4 = ex_pc4_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus random traffic, all checked
// against a transaction-level model of the decode stage.
module tb_id_stage;

    logic        clock = 1'b0;
    logic        reset, if_valid, flush, wb_en;
    logic [31:0] Instruction, PC_plus_4, wb_data;
    logic [4:0]  wb_addr;
    logic        stall, ex_valid;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus_4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_opcode, ex_funct;

    id_stage dut (
        .clock(clock), .reset(reset), .Instruction(Instruction), .PC_plus_4(PC_plus_4),
        .if_valid(if_valid), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_pc_plus_4(ex_pc_plus_4)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned valid, rs_data, rt_data, imm, rs, rt, rd, opcode, funct, pc4;
    } ex_rec_t;

    int unsigned rf_m [32];
    int unsigned id_instr_m, id_pc4_m, id_valid_m;
    ex_rec_t     ex_m;
    logic        last_stall;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input int unsigned rd, rs, rt);
        return 32'((rs << 21) | (rt << 16) | (rd << 11) | 32'h20);
    endfunction

    function automatic logic [31:0] enc_i(input int unsigned op, rs, rt, imm);
        return 32'((op << 26) | (rs << 21) | (rt << 16) | (imm & 32'hFFFF));
    endfunction

    function automatic int unsigned read_m(input int unsigned idx, input logic we,
                                           input int unsigned wa, input int unsigned wd);
        if (idx == 0) return 0;
        if (we && wa == idx) return wd;
        return rf_m[idx];
    endfunction

    function automatic logic stall_m(input logic rst);
        int unsigned rs = (id_instr_m >> 21) % 32;
        int unsigned rt = (id_instr_m >> 16) % 32;
        return !rst && ex_m.valid == 1 && ex_m.opcode == 35 && ex_m.rt != 0 &&
               id_valid_m == 1 && (ex_m.rt == rs || ex_m.rt == rt);
    endfunction

    task automatic model_edge(input logic rst, input int unsigned ins, pc4, input logic ifv,
                              fl, we, input int unsigned wa, wd, input logic st);
        ex_rec_t n;
        int unsigned op, low;
        n = '{default: 0};
        if (!(rst || fl || st)) begin
            op        = id_instr_m >> 26;
            low       = id_instr_m % 65536;
            n.valid   = id_valid_m;
            n.opcode  = op;
            n.rs      = (id_instr_m >> 21) % 32;
            n.rt      = (id_instr_m >> 16) % 32;
            n.rd      = (id_instr_m >> 11) % 32;
            n.funct   = id_instr_m % 64;
            n.imm     = (op >= 12 && op <= 14) ? low :
                        (low >= 32768 ? low + 32'hFFFF0000 : low);
            n.rs_data = read_m(n.rs, we, wa, wd);
            n.rt_data = read_m(n.rt, we, wa, wd);
            n.pc4     = id_pc4_m;
        end
        ex_m = n;
        if (rst || fl) begin
            id_instr_m = 0; id_pc4_m = 0; id_valid_m = 0;
        end else if (!st) begin
            id_instr_m = ins; id_pc4_m = pc4; id_valid_m = ifv ? 1 : 0;
        end
        if (we && wa != 0) rf_m[wa] = wd;
    endtask

    task automatic step(input logic rst, input logic [31:0] ins, pc4, input logic ifv, fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic exp_st;
        @(negedge clock);
        reset = rst; Instruction = ins; PC_plus_4 = pc4; if_valid = ifv;
        flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        exp_st     = stall_m(rst);
        last_stall = stall;
        check_eq("stall", 32'(stall), 32'(exp_st));
        @(posedge clock);
        model_edge(rst, ins, pc4, ifv, fl, we, 32'(wa), wd, exp_st);
        #1;
        check_eq("ex_valid", 32'(ex_valid), ex_m.valid);
        check_eq("ex_rs_data", ex_rs_data, ex_m.rs_data);
        check_eq("ex_rt_data", ex_rt_data, ex_m.rt_data);
        check_eq("ex_imm", ex_imm, ex_m.imm);
        check_eq("ex_rs", 32'(ex_rs), ex_m.rs);
        check_eq("ex_rt", 32'(ex_rt), ex_m.rt);
        check_eq("ex_rd", 32'(ex_rd), ex_m.rd);
        check_eq("ex_opcode", 32'(ex_opcode), ex_m.opcode);
        check_eq("ex_funct", 32'(ex_funct), ex_m.funct);
        check_eq("ex_pc4", ex_pc_plus_4, ex_m.pc4);
    endtask

    // Idle fetch slot: no valid instruction, no write-back.
    task automatic idle(input logic fl);
        step(1'b0, 32'h0, 32'h0, 1'b0, fl, 1'b0, 5'd0, 32'h0);
    endtask

    function automatic logic [31:0] rand_instr();
        int unsigned rs = $urandom_range(0, 7);
        int unsigned rt = $urandom_range(0, 7);
        int unsigned rd = $urandom_range(0, 7);
        int unsigned im = $urandom_range(0, 65535);
        case ($urandom_range(0, 6))
            0:       return enc_i(35, rs, rt, im);
            1:       return enc_i($urandom_range(12, 14), rs, rt, im);
            2:       return enc_i(8, rs, rt, im);
            3:       return enc_i(4, rs, rt, im);
            6:       return $urandom;
            default: return enc_r(rd, rs, rt);
        endcase
    endfunction

    initial begin
        id_instr_m = 0; id_pc4_m = 0; id_valid_m = 0;
        ex_m = '{default: 0};
        foreach (rf_m[i]) rf_m[i] = 0;
        last_stall = 1'b0;

        // Populate the register file while reset is held with a valid fetch.
        for (int r = 0; r < 32; r++)
            step(1'b1, rand_instr(), $urandom, 1'b1, 1'b0, 1'b1, 5'(r), $urandom);
        check_eq("rst_ex_valid", 32'(ex_valid), 32'h0);
        check_eq("rst_stall", 32'(last_stall), 32'h0);
        check_eq("rst_ex_pc4", ex_pc_plus_4, 32'h0);

        // First instruction after reset, with same-cycle write-back bypass of $5.
        step(1'b0, enc_r(3, 5, 0), 32'h0000_1004, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check_eq("lat_edge1_valid", 32'(ex_valid), 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678);
        check_eq("lat_edge2_valid", 32'(ex_valid), 32'h1);
        check_eq("lat_pc4", ex_pc_plus_4, 32'h0000_1004);
        check_eq("byp_rs", ex_rs_data, 32'h1234_5678);
        check_eq("byp_r0", ex_rt_data, 32'h0);

        // Writes to $0 are discarded, including the bypass.
        step(1'b0, enc_r(3, 0, 0), 32'h8, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        check_eq("r0_rs", ex_rs_data, 32'h0);
        check_eq("r0_rt", ex_rt_data, 32'h0);

        step(1'b0, enc_i(13, 0, 2, 32'h8000), 32'h10, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b0, enc_i(8, 0, 2, 32'h8000), 32'h14, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check_eq("ori_imm", ex_imm, 32'h0000_8000);
        step(1'b0, enc_i(4, 1, 2, 32'hFFFF), 32'h18, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check_eq("addi_imm", ex_imm, 32'hFFFF_8000);
        idle(1'b0);
        check_eq("beq_imm", ex_imm, 32'hFFFF_FFFF);

        // Load-use: one stall cycle, one bubble, then the loaded value via bypass.
        step(1'b0, enc_i(35, 1, 4, 0), 32'h20, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b0, enc_r(6, 4, 2), 32'h24, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        idle(1'b0);
        check_eq("lu_stall", 32'(last_stall), 32'h1);
        check_eq("lu_bubble", 32'(ex_valid), 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd4, 32'hCAFE_BABE);
        check_eq("lu_stall_once", 32'(last_stall), 32'h0);
        check_eq("lu_valid", 32'(ex_valid), 32'h1);
        check_eq("lu_rs_data", ex_rs_data, 32'hCAFE_BABE);
        check_eq("lu_pc4", ex_pc_plus_4, 32'h24);

        // No stall for a load to $0, nor for an unrelated consumer.
        step(1'b0, enc_i(35, 1, 0, 0), 32'h30, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b0, enc_r(6, 0, 2), 32'h34, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        idle(1'b0);
        check_eq("nostall_r0", 32'(last_stall), 32'h0);
        step(1'b0, enc_i(35, 1, 4, 0), 32'h40, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b0, enc_r(6, 5, 2), 32'h44, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        idle(1'b0);
        check_eq("nostall_other", 32'(last_stall), 32'h0);

        // Flush during an active load-use stall kills the stalled instruction.
        step(1'b0, enc_i(35, 1, 4, 0), 32'h50, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b0, enc_r(6, 2, 4), 32'h54, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        idle(1'b1);
        check_eq("fl_stall_seen", 32'(last_stall), 32'h1);
        check_eq("fl_bubble", 32'(ex_valid), 32'h0);
        idle(1'b0);
        check_eq("fl_killed", 32'(ex_valid), 32'h0);
        check_eq("fl_nostall", 32'(last_stall), 32'h0);

        for (int c = 0; c < 1500; c++)
            step($urandom_range(0, 49) == 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
